// File: rtl/mdp_pkg.sv
// mdp_pkg: shared memory-dependence-prediction widths and types (common with SSIT)
//   SSID_W     store set ID width
//   TAG_W      ROB tag width
//   RENAME_W   rename slots per cycle (slot 0 is oldest)
//   LFST_DEPTH entries in the last fetched store table
package mdp_pkg;
    localparam int SSID_W     = 7;
    localparam int TAG_W      = 7;
    localparam int RENAME_W   = 4;
    localparam int LFST_DEPTH = 2 ** SSID_W;
    typedef logic [SSID_W-1:0] ssid_t;
    typedef logic [TAG_W-1:0]  tag_t;
endpackage

// File: rtl/lfst_group_bypass.sv
// lfst_group_bypass: intra-group store forwarding for one rename group
//   i_mem      slot is a valid memory op with a valid SSID
//   i_st       slot is a store
//   i_ssid     per-slot SSID
//   i_tag      per-slot ROB tag
//   o_byp_v    an older same-SSID store exists in the group
//   o_byp_tag  tag of the nearest such older store
//   o_wr       slot is the youngest store of its SSID in the group (table writer)
module lfst_group_bypass
    import mdp_pkg::*;
(
    input  logic  [RENAME_W-1:0] i_mem,
    input  logic  [RENAME_W-1:0] i_st,
    input  ssid_t [RENAME_W-1:0] i_ssid,
    input  tag_t  [RENAME_W-1:0] i_tag,
    output logic  [RENAME_W-1:0] o_byp_v,
    output tag_t  [RENAME_W-1:0] o_byp_tag,
    output logic  [RENAME_W-1:0] o_wr
);
    logic [RENAME_W-1:0] w_st_mem;

    assign w_st_mem = i_mem & i_st;

    // Ascending k scan: the last older match seen is the nearest one.
    always_comb begin
        o_byp_v   = '0;
        o_byp_tag = '0;
        o_wr      = w_st_mem;
        for (int i = 0; i < RENAME_W; i++)
            for (int k = 0; k < RENAME_W; k++)
                if (w_st_mem[k] && i_ssid[k] == i_ssid[i]) begin
                    if (k < i) begin
                        o_byp_v[i]   = 1'b1;
                        o_byp_tag[i] = i_tag[k];
                    end else if (k > i) begin
                        o_wr[i] = 1'b0;
                    end
                end
    end
endmodule

// File: rtl/lfst.sv
// lfst: last fetched store table; per renamed load/store returns the ROB tag of the
// most recent in-flight store of the same store set (registered, latency 1)
//   clock, reset_n                 clock, synchronous active-low reset
//   ren_v_in/ren_st_in/ren_ld_in   per-slot valid / store / load
//   ssid*_in, ssv*_in, tag*_in     per-slot SSID, SSID valid, ROB tag
//   st_iss_*                       issued store releases its set entry
//   flush_in                       invalidate whole table, drop this cycle's work
//   dep_v_out, dep_tag*_out        per-slot dependence and producer store tag
module lfst
    import mdp_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic [RENAME_W-1:0] ren_v_in,
    input  logic [RENAME_W-1:0] ren_st_in,
    input  logic [RENAME_W-1:0] ren_ld_in,
    input  logic [SSID_W-1:0]   ssid0_in,
    input  logic [SSID_W-1:0]   ssid1_in,
    input  logic [SSID_W-1:0]   ssid2_in,
    input  logic [SSID_W-1:0]   ssid3_in,
    input  logic                ssv0_in,
    input  logic                ssv1_in,
    input  logic                ssv2_in,
    input  logic                ssv3_in,
    input  logic [TAG_W-1:0]    tag0_in,
    input  logic [TAG_W-1:0]    tag1_in,
    input  logic [TAG_W-1:0]    tag2_in,
    input  logic [TAG_W-1:0]    tag3_in,
    input  logic                st_iss_v_in,
    input  logic [SSID_W-1:0]   st_iss_ssid_in,
    input  logic [TAG_W-1:0]    st_iss_tag_in,
    input  logic                flush_in,
    output logic [RENAME_W-1:0] dep_v_out,
    output logic [TAG_W-1:0]    dep_tag0_out,
    output logic [TAG_W-1:0]    dep_tag1_out,
    output logic [TAG_W-1:0]    dep_tag2_out,
    output logic [TAG_W-1:0]    dep_tag3_out
);
    ssid_t [RENAME_W-1:0] w_ssid;
    tag_t  [RENAME_W-1:0] w_tag;
    tag_t  [RENAME_W-1:0] w_byp_tag;
    tag_t  [RENAME_W-1:0] w_dt;
    logic  [RENAME_W-1:0] w_ssv;
    logic  [RENAME_W-1:0] w_mem;
    logic  [RENAME_W-1:0] w_byp_v;
    logic  [RENAME_W-1:0] w_wr;
    logic  [RENAME_W-1:0] w_kill;
    logic  [RENAME_W-1:0] w_dv;
    logic                 w_iss_clr;

    logic [LFST_DEPTH-1:0] r_v;
    tag_t                  r_tag [LFST_DEPTH];
    logic [RENAME_W-1:0]   r_dep_v;
    tag_t [RENAME_W-1:0]   r_dep_tag;

    assign w_ssid = {ssid3_in, ssid2_in, ssid1_in, ssid0_in};
    assign w_tag  = {tag3_in, tag2_in, tag1_in, tag0_in};
    assign w_ssv  = {ssv3_in, ssv2_in, ssv1_in, ssv0_in};
    assign w_mem  = ren_v_in & (ren_ld_in | ren_st_in) & w_ssv;

    lfst_group_bypass u_byp (
        .i_mem     (w_mem),
        .i_st      (ren_st_in),
        .i_ssid    (w_ssid),
        .i_tag     (w_tag),
        .o_byp_v   (w_byp_v),
        .o_byp_tag (w_byp_tag),
        .o_wr      (w_wr)
    );

    // A store issuing this very cycle with the recorded tag means the entry is stale
    // for lookups made now, even though the table only clears at the edge.
    always_comb begin
        w_kill = '0;
        w_dv   = '0;
        w_dt   = '0;
        for (int i = 0; i < RENAME_W; i++) begin
            w_kill[i] = st_iss_v_in && st_iss_ssid_in == w_ssid[i] &&
                        st_iss_tag_in == r_tag[w_ssid[i]];
            w_dv[i]   = w_mem[i] && (w_byp_v[i] || (r_v[w_ssid[i]] && !w_kill[i]));
            w_dt[i]   = !w_dv[i] ? '0 : w_byp_v[i] ? w_byp_tag[i] : r_tag[w_ssid[i]];
        end
    end

    assign w_iss_clr = st_iss_v_in && r_v[st_iss_ssid_in] &&
                       r_tag[st_iss_ssid_in] == st_iss_tag_in;

    // Store writes follow the issue clear so a same-SSID write wins the edge.
    always_ff @(posedge clock) begin
        if (!reset_n || flush_in) begin
            r_v       <= '0;
            r_dep_v   <= '0;
            r_dep_tag <= '0;
        end else begin
            r_dep_v   <= w_dv;
            r_dep_tag <= w_dt;
            if (w_iss_clr)
                r_v[st_iss_ssid_in] <= 1'b0;
            for (int i = 0; i < RENAME_W; i++)
                if (w_wr[i])
                    r_v[w_ssid[i]] <= 1'b1;
        end
    end

    // Tags are qualified by r_v, so they need no reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < RENAME_W; i++)
            if (reset_n && !flush_in && w_wr[i])
                r_tag[w_ssid[i]] <= w_tag[i];
    end

    assign dep_v_out    = r_dep_v;
    assign dep_tag0_out = r_dep_tag[0];
    assign dep_tag1_out = r_dep_tag[1];
    assign dep_tag2_out = r_dep_tag[2];
    assign dep_tag3_out = r_dep_tag[3];
endmodule
